// File: rtl/dmx_frame_tx.sv
// DMX512 packet transmitter: BREAK, Mark-After-Break, start-code slot and
// NUM_CH channel slots, paced by the divider's bit tick.
module dmx_frame_tx #(
    parameter int NUM_CH     = 512,
    parameter int BREAK_BITS = 25,
    parameter int MAB_BITS   = 3
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic       bit_en,
    input  logic       start,
    input  logic [7:0] ch_data,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic       ch_rd,
    output logic [8:0] ch_addr
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_BREAK,
        ST_MAB,
        ST_SLOT
    } state_t;

    localparam logic [9:0] LAST_SLOT  = 10'(NUM_CH);
    localparam logic [7:0] BREAK_LAST = 8'(BREAK_BITS - 1);
    localparam logic [7:0] MAB_LAST   = 8'(MAB_BITS - 1);

    state_t      state_r;
    logic        tx_r;
    logic        busy_r;
    logic        done_r;
    logic        ch_rd_r;
    logic [8:0]  ch_addr_r;
    logic [3:0]  bit_cnt_r;
    logic [9:0]  slot_cnt_r;
    logic [7:0]  phase_cnt_r;
    logic [7:0]  shift_r;
    logic [7:0]  next_byte_r;

    assign tx      = tx_r;
    assign busy    = busy_r;
    assign done    = done_r;
    assign ch_rd   = ch_rd_r;
    assign ch_addr = ch_addr_r;

    // Frame sequencer; bit_cnt_r is the index of the slot bit currently on the line.
    always_ff @(posedge int_osc or posedge reset) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            tx_r        <= 1'b1;
            busy_r      <= 1'b0;
            done_r      <= 1'b0;
            ch_rd_r     <= 1'b0;
            ch_addr_r   <= 9'd0;
            bit_cnt_r   <= 4'd0;
            slot_cnt_r  <= 10'd0;
            phase_cnt_r <= 8'd0;
            shift_r     <= 8'h00;
            next_byte_r <= 8'h00;
        end else begin
            done_r  <= 1'b0;
            ch_rd_r <= 1'b0;
            if (ch_rd_r) begin
                next_byte_r <= ch_data;
            end
            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_ARMED;
                        busy_r  <= 1'b1;
                    end
                end
                ST_ARMED: begin
                    if (bit_en) begin
                        tx_r        <= 1'b0;
                        phase_cnt_r <= 8'd0;
                        state_r     <= ST_BREAK;
                    end
                end
                ST_BREAK: begin
                    if (bit_en) begin
                        if (phase_cnt_r == BREAK_LAST) begin
                            tx_r        <= 1'b1;
                            phase_cnt_r <= 8'd0;
                            state_r     <= ST_MAB;
                        end else begin
                            phase_cnt_r <= phase_cnt_r + 8'd1;
                        end
                    end
                end
                ST_MAB: begin
                    if (bit_en) begin
                        if (phase_cnt_r == MAB_LAST) begin
                            tx_r       <= 1'b0;
                            bit_cnt_r  <= 4'd0;
                            slot_cnt_r <= 10'd0;
                            shift_r    <= 8'h00;
                            state_r    <= ST_SLOT;
                        end else begin
                            phase_cnt_r <= phase_cnt_r + 8'd1;
                        end
                    end
                end
                ST_SLOT: begin
                    if (bit_en) begin
                        if (bit_cnt_r == 4'd10) begin
                            if (slot_cnt_r == LAST_SLOT) begin
                                state_r <= ST_IDLE;
                                busy_r  <= 1'b0;
                                done_r  <= 1'b1;
                                tx_r    <= 1'b1;
                            end else begin
                                slot_cnt_r <= slot_cnt_r + 10'd1;
                                bit_cnt_r  <= 4'd0;
                                tx_r       <= 1'b0;
                                shift_r    <= next_byte_r;
                            end
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 4'd1;
                            if (bit_cnt_r < 4'd8) begin
                                tx_r <= shift_r[bit_cnt_r[2:0]];
                            end else begin
                                tx_r <= 1'b1;
                            end
                            // Prefetch the next slot's byte as stop bit 1 begins.
                            if (bit_cnt_r == 4'd8 && slot_cnt_r != LAST_SLOT) begin
                                ch_rd_r   <= 1'b1;
                                ch_addr_r <= slot_cnt_r[8:0];
                            end
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                    tx_r    <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

endmodule
